// File: rtl/sine_cos_rom.sv
// Dual-port signed sine ROM, 1-cycle registered read with per-port enable hold.
// Define QUARTER_WAVE_EN to store only the first quadrant and fold addresses per port.
module sine_cos_rom #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 12,
  parameter int AMPLITUDE  = 2047
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic [ADDR_WIDTH-1:0]        addra,
  output logic signed [DATA_WIDTH-1:0] douta,
  input  logic                         enb,
  input  logic [ADDR_WIDTH-1:0]        addrb,
  output logic signed [DATA_WIDTH-1:0] doutb
);

  localparam int AW    = ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam int NQ    = DEPTH / 4;
  // pi/2 in unsigned fixed point with 60 fractional bits
  localparam logic [127:0] HALF_PI = 128'h1921FB54442D1846;

  // round(AMPLITUDE * sin(pi/2 * j/NQ)) for j in 0..NQ, via a Taylor series in fixed point
  function automatic int unsigned qmag(input int j);
    logic [127:0] x, term, sum;
    x    = (HALF_PI * 128'(j)) / 128'(NQ);
    term = x;
    sum  = x;
    for (int n = 1; n <= 13; n++) begin
      term = ((((term * x) >> 60) * x) >> 60) / 128'((2 * n) * (2 * n + 1));
      if (n % 2 == 1) sum = sum - term;
      else            sum = sum + term;
    end
    sum = sum * 128'(AMPLITUDE) + (128'(1) << 59);
    return 32'(sum >> 60);
  endfunction

  function automatic logic signed [DW-1:0] tval(input int k);
    int q, p, v;
    q = k / NQ;
    p = k % NQ;
    v = int'((q == 0 || q == 2) ? qmag(p) : qmag(NQ - p));
    if (q >= 2) v = -v;
    return DW'(v);
  endfunction

`ifdef QUARTER_WAVE_EN
  logic signed [DW-1:0] qrom [NQ+1];
  for (genvar j = 0; j <= NQ; j++) begin : g_qrom
    assign qrom[j] = DW'(qmag(j));
  end
`else
  logic signed [DW-1:0] rom [DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom[k] = tval(k);
  end
`endif

  for (genvar pt = 0; pt < 2; pt++) begin : g_port
    logic [AW-1:0]        addr;
    logic signed [DW-1:0] dat;
    assign addr = (pt == 0) ? addra : addrb;
`ifdef QUARTER_WAVE_EN
    logic [1:0]           quad;
    logic [AW-1:0]        phase, fidx;
    logic signed [DW-1:0] mag;
    assign quad  = addr[AW-1 -: 2];
    assign phase = addr & AW'(NQ - 1);
    // odd quadrants read the quarter backwards; the upper half is negated
    assign fidx  = quad[0] ? AW'(NQ) - phase : phase;
    assign mag   = qrom[fidx[AW-2:0]];
    assign dat   = quad[1] ? -mag : mag;
`else
    assign dat   = rom[addr];
`endif
  end

  logic signed [DW-1:0] douta_q, douta_d, doutb_q, doutb_d;

  always_comb begin
    douta_d = douta_q;
    doutb_d = doutb_q;
    if (ena) douta_d = g_port[0].dat;
    if (enb) doutb_d = g_port[1].dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      douta_q <= '0;
      doutb_q <= '0;
    end else begin
      douta_q <= douta_d;
      doutb_q <= doutb_d;
    end
  end

  assign douta = douta_q;
  assign doutb = doutb_q;

endmodule

// File: tb/tb_sine_cos_rom.sv
// Randomized and directed bench for sine_cos_rom against a $sin-based reference table.
module tb_sine_cos_rom;
  localparam int AW    = 10;
  localparam int DW    = 12;
  localparam int AMP   = 2047;
  localparam int DEPTH = 1024;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 ena   = 1'b0;
  logic                 enb   = 1'b0;
  logic [AW-1:0]        addra = '0;
  logic [AW-1:0]        addrb = '0;
  logic signed [DW-1:0] douta, doutb;

  sine_cos_rom #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AMPLITUDE(AMP)) dut (
    .clk(clk), .rst_n(rst_n),
    .ena(ena), .addra(addra), .douta(douta),
    .enb(enb), .addrb(addrb), .doutb(doutb)
  );

  always #5 clk = ~clk;

  int                 tbl [DEPTH];
  int                 checks = 0;
  int                 errors = 0;
  logic signed [31:0] exp_a = 0;
  logic signed [31:0] exp_b = 0;
  bit                 cmp_on = 1'b0;
  logic signed [31:0] sa [DEPTH];
  logic signed [31:0] sb [DEPTH];

  function automatic int ref_sin(input int k);
    real r;
    r = real'(AMP) * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(DEPTH));
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(-r + 0.5);
  endfunction

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: enabled read returns the table entry one edge later, reset forces zero.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_a <= 0;
      exp_b <= 0;
    end else begin
      if (ena) exp_a <= tbl[addra];
      if (enb) exp_b <= tbl[addrb];
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cycle_a", douta, exp_a);
      check("cycle_b", doutb, exp_b);
    end
  end

  int keys [7] = '{0, 64, 128, 256, 512, 768, 896};
  int kval [7] = '{0, 783, 1447, 2047, 0, -2047, -1447};

  initial begin
    for (int k = 0; k < DEPTH; k++) tbl[k] = ref_sin(k);
    check("pin_t1",    tbl[1],    13);
    check("pin_t64",   tbl[64],   783);
    check("pin_t128",  tbl[128],  1447);
    check("pin_t256",  tbl[256],  2047);
    check("pin_t512",  tbl[512],  0);
    check("pin_t768",  tbl[768],  -2047);
    check("pin_t1023", tbl[1023], -13);
    cmp_on = 1'b1;

    // reset held with enables active
    ena = 1'b1; enb = 1'b1;
    repeat (5) begin
      addra = AW'($urandom);
      addrb = AW'($urandom);
      tick();
      check("reset_a", douta, 0);
      check("reset_b", doutb, 0);
    end
    addra = 10'd256; addrb = 10'd768;
    rst_n = 1'b1;
    #2;
    check("pre_first_a", douta, 0);
    check("pre_first_b", doutb, 0);
    tick();
    check("first_a", douta, 2047);
    check("first_b", doutb, -2047);

    // asynchronous reset mid-stream
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_a", douta, 0);
    check("async_b", doutb, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_a", douta, 2047);
    check("post_rst_b", doutb, -2047);

    // key points on port A, random traffic on port B
    for (int i = 0; i < 7; i++) begin
      addra = AW'(keys[i]);
      addrb = AW'($urandom);
      tick();
      check("keypoint", douta, kval[i]);
    end

    // wrap neighbours back to back
    addra = 10'd1023;
    tick();
    check("wrap_1023", douta, -13);
    addra = 10'd1;
    tick();
    check("wrap_1", douta, 13);

    // sine/cosine sweep
    for (int i = 0; i < 1200; i++) begin
      addra = AW'(i % DEPTH);
      addrb = AW'((i + 256) % DEPTH);
      tick();
      sa[i % DEPTH] = douta;
      sb[i % DEPTH] = doutb;
      if (i % DEPTH == 0)   check("cos_at0", doutb, 2047);
      if (i % DEPTH == 768) check("cos_at768", doutb, 0);
    end
    for (int k = 0; k < DEPTH; k++) check("sin_cos_shift", sb[k], sa[(k + 256) % DEPTH]);
    for (int k = 1; k < DEPTH; k++) check("odd_symmetry", sa[k] + sa[DEPTH - k], 0);

    // enable hold on port A while port B keeps reading
    ena = 1'b1; addra = 10'd256;
    tick();
    check("hold_load", douta, 2047);
    ena = 1'b0;
    repeat (10) begin
      addra = AW'($urandom);
      addrb = AW'($urandom);
      tick();
      check("hold_a", douta, 2047);
    end
    ena = 1'b1; addra = 10'd512;
    tick();
    check("hold_release", douta, 0);

    // randomized traffic including equal addresses
    for (int i = 0; i < 600; i++) begin
      ena   = 1'($urandom);
      enb   = 1'($urandom);
      addra = AW'($urandom);
      addrb = ($urandom_range(0, 3) == 0) ? addra : AW'($urandom);
      tick();
    end
    enb = 1'b1; ena = 1'b1;
    addra = 10'd300; addrb = 10'd300;
    tick();
    check("same_addr", douta, doutb);
    check("same_addr_val", douta, tbl[300]);

    @(posedge clk);
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
